// File: rtl/slot_pkg.sv
// Shared types and sizes for the slot machine blocks (controller, rng, display).
package slot_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned NUM_REELS = 3;
    localparam int unsigned IDX_W     = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        STROBE,
        CAPTURE,
        SCORE
    } state_e;

    typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/slot_spin_ctrl_rise_detect.sv
// Rising-edge detector: registers the level input and flags its 0->1 transition.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic pulse_c_o
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign pulse_c_o = d_i & ~d_q;

endmodule

// File: rtl/slot_spin_ctrl.sv
// Slot machine game controller: button press -> three rng strobes -> reel capture,
// scoring and a saturating credit balance.
module slot_spin_ctrl
    import slot_pkg::*;
#(
    parameter int unsigned CRED_W        = 8,
    parameter int unsigned START_CREDITS = 10,
    parameter int unsigned BET           = 1,
    parameter int unsigned PAY2          = 2,
    parameter int unsigned PAY3          = 10,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_i,
    input  logic [DIGIT_W-1:0] digit_i,
    output logic               spin_o,
    output logic [DIGIT_W-1:0] reel0_o,
    output logic [DIGIT_W-1:0] reel1_o,
    output logic [DIGIT_W-1:0] reel2_o,
    output logic [CRED_W-1:0]  credits_o,
    output logic               busy_o,
    output logic               win_o,
    output logic               no_funds_o
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    // Sum is wide enough that credits + payout can never wrap before saturation.
    localparam int unsigned SUM_W = ((CRED_W > 32) ? CRED_W : 32) + 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CRED_W-1:0] CRED_MAX  = '1;
    localparam logic [CRED_W-1:0] CRED_BET  = CRED_W'(BET);
    localparam logic [CRED_W-1:0] CRED_INIT = CRED_W'(START_CREDITS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REELS - 1);

    state_e                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [NUM_REELS-1:0][DIGIT_W-1:0] reels_q, reels_d;
    logic [CRED_W-1:0]                 credits_q, credits_d;
    logic                              spin_q, spin_d;
    logic                              busy_q, busy_d;
    logic                              win_q, win_d;
    logic                              no_funds_q, no_funds_d;

    logic                              press_c;
    logic [SUM_W-1:0]                  pay_c;
    logic [SUM_W-1:0]                  sum_c;

    rise_detect u_rise_detect (
        .clk       (clk),
        .rst       (rst),
        .d_i       (btn_i),
        .pulse_c_o (press_c)
    );

    // Payout for the current reel contents; only consumed in SCORE.
    always_comb begin
        pay_c = '0;
        if ((reels_q[0] == reels_q[1]) && (reels_q[1] == reels_q[2])) begin
            pay_c = SUM_W'(PAY3);
        end else if ((reels_q[0] == reels_q[1]) || (reels_q[1] == reels_q[2]) ||
                     (reels_q[0] == reels_q[2])) begin
            pay_c = SUM_W'(PAY2);
        end
        sum_c = SUM_W'(credits_q) + pay_c;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        reels_d    = reels_q;
        credits_d  = credits_q;
        win_d      = 1'b0;
        no_funds_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (press_c) begin
                    if (credits_q >= CRED_BET) begin
                        credits_d = credits_q - CRED_BET;
                        idx_d     = '0;
                        cnt_d     = CNT_LOAD;
                        state_d   = WAIT;
                    end else begin
                        no_funds_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STROBE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                reels_d[idx_q] = digit_i;
                if (idx_q == LAST_IDX) begin
                    state_d = SCORE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            SCORE: begin
                if (pay_c != '0) begin
                    win_d     = 1'b1;
                    credits_d = (sum_c > SUM_W'(CRED_MAX)) ? CRED_MAX : CRED_W'(sum_c);
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs reflect the state being entered.
        spin_d = (state_d == STROBE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            reels_q    <= '0;
            credits_q  <= CRED_INIT;
            spin_q     <= 1'b0;
            busy_q     <= 1'b0;
            win_q      <= 1'b0;
            no_funds_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            reels_q    <= reels_d;
            credits_q  <= credits_d;
            spin_q     <= spin_d;
            busy_q     <= busy_d;
            win_q      <= win_d;
            no_funds_q <= no_funds_d;
        end
    end

    assign spin_o     = spin_q;
    assign reel0_o    = reels_q[0];
    assign reel1_o    = reels_q[1];
    assign reel2_o    = reels_q[2];
    assign credits_o  = credits_q;
    assign busy_o     = busy_q;
    assign win_o      = win_q;
    assign no_funds_o = no_funds_q;

endmodule

// File: tb/tb_slot_spin_ctrl.sv
// Self-checking bench for slot_spin_ctrl: default, zero-credit and 4-bit saturating instances.
module tb_slot_spin_ctrl;

    typedef struct {
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [7:0] exp_cred;
        logic       exp_win;
    } vec_t;

    typedef struct {
        logic [3:0] r0;
        logic [3:0] r1;
        logic [3:0] r2;
        logic [7:0] cred;
        logic       win;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] digit = 4'h0;
    logic [3:0] cur_digits [3];

    logic btn_m = 1'b0, btn_n = 1'b0, btn_s = 1'b0;
    logic spin_m, busy_m, win_m, nf_m;
    logic spin_n, busy_n, win_n, nf_n;
    logic spin_s, busy_s, win_s, nf_s;
    logic [3:0] r0_m, r1_m, r2_m, r0_n, r1_n, r2_n, r0_s, r1_s, r2_s;
    logic [7:0] cred_m, cred_n;
    logic [3:0] cred_s;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int spins_m = 0, spins_n = 0;
    int wide_err = 0, gap_err = 0;
    int last_stb = 0;
    bit in_game = 0;
    bit spin_prev = 0;
    int stb_idx = 0;

    exp_t sb[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    slot_spin_ctrl u_main (
        .clk(clk), .rst(rst), .btn_i(btn_m), .digit_i(digit), .spin_o(spin_m),
        .reel0_o(r0_m), .reel1_o(r1_m), .reel2_o(r2_m), .credits_o(cred_m),
        .busy_o(busy_m), .win_o(win_m), .no_funds_o(nf_m)
    );

    slot_spin_ctrl #(.START_CREDITS(0)) u_nf (
        .clk(clk), .rst(rst), .btn_i(btn_n), .digit_i(digit), .spin_o(spin_n),
        .reel0_o(r0_n), .reel1_o(r1_n), .reel2_o(r2_n), .credits_o(cred_n),
        .busy_o(busy_n), .win_o(win_n), .no_funds_o(nf_n)
    );

    slot_spin_ctrl #(.CRED_W(4), .START_CREDITS(15)) u_sat (
        .clk(clk), .rst(rst), .btn_i(btn_s), .digit_i(digit), .spin_o(spin_s),
        .reel0_o(r0_s), .reel1_o(r1_s), .reel2_o(r2_s), .credits_o(cred_s),
        .busy_o(busy_s), .win_o(win_s), .no_funds_o(nf_s)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // rng stand-in plus strobe width/spacing monitor.
    always @(negedge clk) begin
        if (spin_m) begin
            if (spin_prev) wide_err++;
            if (in_game && (cyc - last_stb != 6)) gap_err++;
            last_stb = cyc;
            in_game  = 1;
            spins_m++;
        end
        if (spin_n) spins_n++;
        if (spin_m || spin_s) begin
            digit   = cur_digits[stb_idx];
            stb_idx = (stb_idx == 2) ? 0 : stb_idx + 1;
        end
        if (!busy_m) in_game = 0;
        if (!busy_m && !busy_s) stb_idx = 0;
        spin_prev = spin_m;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_game(input vec_t v, input logic [7:0] start);
        exp_t e;
        exp_t got;
        int   n;
        int   wins;
        int   s0;
        e.r0 = v.d0; e.r1 = v.d1; e.r2 = v.d2; e.cred = v.exp_cred; e.win = v.exp_win;
        sb.push_back(e);
        cur_digits[0] = v.d0; cur_digits[1] = v.d1; cur_digits[2] = v.d2;
        s0 = spins_m;
        btn_m = 1'b1;
        tick();
        btn_m = 1'b0;
        chk("debit", 32'(cred_m), 32'(start) - 1);
        chk("busy_rise", 32'(busy_m), 1);
        n = 1;
        wins = 0;
        while (busy_m && n < 40) begin
            tick();
            n++;
            wins += int'(win_m);
        end
        chk("latency", n, 20);
        tick();
        wins += int'(win_m);
        got = sb.pop_front();
        chk("reel0", 32'(r0_m), 32'(got.r0));
        chk("reel1", 32'(r1_m), 32'(got.r1));
        chk("reel2", 32'(r2_m), 32'(got.r2));
        chk("credits", 32'(cred_m), 32'(got.cred));
        chk("win_pulses", wins, got.win ? 1 : 0);
        chk("strobes", spins_m - s0, 3);
    endtask

    initial begin
        int s0;
        int n;
        int wins;
        logic [7:0] prev;

        vecs[0] = '{4'h7, 4'h7, 4'h7, 8'd19, 1'b1};
        vecs[1] = '{4'h3, 4'h3, 4'h5, 8'd20, 1'b1};
        vecs[2] = '{4'h1, 4'h2, 4'h3, 8'd19, 1'b0};
        vecs[3] = '{4'h4, 4'h9, 4'h4, 8'd20, 1'b1};
        vecs[4] = '{4'h0, 4'h6, 4'h6, 8'd21, 1'b1};
        vecs[5] = '{4'hF, 4'hF, 4'hF, 8'd30, 1'b1};
        cur_digits[0] = 4'h0; cur_digits[1] = 4'h0; cur_digits[2] = 4'h0;

        // Reset and idle
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("rst_credits", 32'(cred_m), 10);
        chk("rst_busy", 32'(busy_m), 0);
        chk("rst_reels", {20'd0, r0_m, r1_m, r2_m}, 0);
        chk("rst_spins", spins_m, 0);
        chk("rst_win_nf", {30'd0, win_m, nf_m}, 0);

        // Table of games on the default instance
        prev = 8'd10;
        for (int i = 0; i < 6; i++) begin
            run_game(vecs[i], prev);
            prev = vecs[i].exp_cred;
        end

        // Held button gives exactly one game
        cur_digits[0] = 4'h1; cur_digits[1] = 4'h2; cur_digits[2] = 4'h3;
        s0 = spins_m;
        btn_m = 1'b1;
        repeat (100) tick();
        btn_m = 1'b0;
        tick();
        chk("held_strobes", spins_m - s0, 3);
        chk("held_credits", 32'(cred_m), 29);

        // Press while busy is dropped
        s0 = spins_m;
        btn_m = 1'b1;
        tick();
        btn_m = 1'b0;
        repeat (5) tick();
        btn_m = 1'b1;
        tick();
        btn_m = 1'b0;
        n = 0;
        while (busy_m && n < 40) begin
            tick();
            n++;
        end
        chk("busy_drop_timeout", 32'(busy_m), 0);
        repeat (30) tick();
        chk("busy_drop_strobes", spins_m - s0, 3);
        chk("busy_drop_credits", 32'(cred_m), 28);
        chk("busy_drop_idle", 32'(busy_m), 0);

        // Refused press with no credits
        btn_n = 1'b1;
        tick();
        btn_n = 1'b0;
        chk("nf_pulse", 32'(nf_n), 1);
        chk("nf_busy", 32'(busy_n), 0);
        tick();
        chk("nf_one_cycle", 32'(nf_n), 0);
        repeat (25) tick();
        chk("nf_credits", 32'(cred_n), 0);
        chk("nf_spins", spins_n, 0);

        // Saturation on a 4-bit balance
        cur_digits[0] = 4'h5; cur_digits[1] = 4'h5; cur_digits[2] = 4'h5;
        btn_s = 1'b1;
        tick();
        btn_s = 1'b0;
        chk("sat_debit", 32'(cred_s), 14);
        n = 1;
        wins = 0;
        while (busy_s && n < 40) begin
            tick();
            n++;
            wins += int'(win_s);
        end
        chk("sat_latency", n, 20);
        chk("sat_credits", 32'(cred_s), 15);
        chk("sat_win", wins, 1);

        // Reset during the second WAIT
        cur_digits[0] = 4'h7; cur_digits[1] = 4'h7; cur_digits[2] = 4'h7;
        btn_m = 1'b1;
        tick();
        btn_m = 1'b0;
        repeat (7) tick();
        chk("mid_reel0", 32'(r0_m), 7);
        chk("mid_busy", 32'(busy_m), 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_spin", 32'(spin_m), 0);
        chk("mid_rst_reels", {20'd0, r0_m, r1_m, r2_m}, 0);
        chk("mid_rst_credits", 32'(cred_m), 10);
        chk("mid_rst_busy", 32'(busy_m), 0);
        rst = 1'b0;
        s0 = spins_m;
        repeat (20) tick();
        chk("post_rst_spins", spins_m - s0, 0);
        chk("post_rst_idle", 32'(busy_m), 0);

        chk("strobe_width", wide_err, 0);
        chk("strobe_spacing", gap_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
